// File: rtl/board_ctrl_n.sv
// board_ctrl_n: NxN chessboard state, cursor, pick/place FSM with turn
// enforcement, move counter and a combinational pixel renderer.
// Optional one-level undo is compiled in when the UNDO_EN macro is defined.
module board_ctrl_n #(
  parameter int N           = 8,
  parameter int SQ_LOG2     = 5,
  parameter int X0          = 322,
  parameter int Y0          = 122,
  parameter int LETTER_BASE = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bright,
  input  logic               up,
  input  logic               down,
  input  logic               left,
  input  logic               right,
  input  logic               select,
  input  logic               cancel,
  input  logic               undo,
  input  logic [9:0]         hCount,
  input  logic [9:0]         vCount,
  input  logic               sprite_on,
  output logic [2:0]         sq_piece,
  output logic [SQ_LOG2-1:0] px_x,
  output logic [SQ_LOG2-1:0] px_y,
  output logic [11:0]        rgb,
  output logic [3:0]         last_x,
  output logic [3:0]         last_y,
  output logic               turn,
  output logic [9:0]         move_count,
  output logic               held,
  output logic               err
);

  localparam logic [2:0] EMPTY  = 3'd0;
  localparam logic [2:0] PAWN   = 3'd1;
  localparam logic [2:0] KNIGHT = 3'd2;
  localparam logic [2:0] BISHOP = 3'd3;
  localparam logic [2:0] ROOK   = 3'd4;
  localparam logic [2:0] QUEEN  = 3'd5;
  localparam logic [2:0] KING   = 3'd6;
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] HELD   = 1'b1;
  localparam logic [2:0] LAST   = 3'(N - 1);
  localparam int         BOARD_PX = N << SQ_LOG2;

  // Back-rank piece for column c (R N B Q K B N R).
  function automatic logic [2:0] back_rank(input int c);
    logic [2:0] p;
    case (c)
      0:       p = ROOK;
      1:       p = KNIGHT;
      2:       p = BISHOP;
      3:       p = QUEEN;
      4:       p = KING;
      5:       p = BISHOP;
      6:       p = KNIGHT;
      7:       p = ROOK;
      default: p = EMPTY;
    endcase
    return p;
  endfunction

  // Starting {team, code} for square (row r, column c); black on top.
  function automatic logic [3:0] init_sq(input int r, input int c);
    logic [3:0] v;
    if (r == 0)          v = {1'b1, back_rank(c)};
    else if (r == 1)     v = {1'b1, PAWN};
    else if (r == N - 2) v = {1'b0, PAWN};
    else if (r == N - 1) v = {1'b0, back_rank(c)};
    else                 v = 4'd0;
    return v;
  endfunction

  logic [3:0] board_q [N][N];
  logic [3:0] board_d [N][N];
  logic [2:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic [2:0] fx_q, fx_d, fy_q, fy_d;
  logic [0:0] state_q, state_d;
  logic       turn_q, turn_d, err_q, err_d;
  logic [9:0] cnt_q, cnt_d;
  logic [3:0] lx_q, lx_d, ly_q, ly_d;
  logic [3:0] cur_s, moved_s;
  logic [2:0] dest_code_s;

`ifdef UNDO_EN
  logic       uv_q, uv_d;
  logic [2:0] ufx_q, ufx_d, ufy_q, ufy_d, utx_q, utx_d, uty_q, uty_d;
  logic [3:0] umov_q, umov_d, ucap_q, ucap_d;
`else
  logic       undo_unused_s;
  assign undo_unused_s = undo;
`endif

  // Next-state logic: one prioritised pulse acted on per cycle.
  always_comb begin
    board_d = board_q;
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;
    fx_d    = fx_q;
    fy_d    = fy_q;
    state_d = state_q;
    turn_d  = turn_q;
    cnt_d   = cnt_q;
    lx_d    = lx_q;
    ly_d    = ly_q;
    err_d   = 1'b0;
`ifdef UNDO_EN
    uv_d   = uv_q;
    ufx_d  = ufx_q;
    ufy_d  = ufy_q;
    utx_d  = utx_q;
    uty_d  = uty_q;
    umov_d = umov_q;
    ucap_d = ucap_q;
`endif
    cur_s   = board_q[ypos_q][xpos_q];
    moved_s = board_q[fy_q][fx_q];
    // A pawn reaching the far rank (row 0 for white, N-1 for black) promotes.
    if (moved_s[2:0] == PAWN &&
        ((!moved_s[3] && ypos_q == 3'd0) || (moved_s[3] && ypos_q == LAST)))
      dest_code_s = QUEEN;
    else
      dest_code_s = moved_s[2:0];

    if (right) begin
      xpos_d = (xpos_q == LAST) ? 3'd0 : xpos_q + 3'd1;
    end else if (left) begin
      xpos_d = (xpos_q == 3'd0) ? LAST : xpos_q - 3'd1;
    end else if (up) begin
      ypos_d = (ypos_q == 3'd0) ? LAST : ypos_q - 3'd1;
    end else if (down) begin
      ypos_d = (ypos_q == LAST) ? 3'd0 : ypos_q + 3'd1;
    end else if (select) begin
      if (state_q == IDLE) begin
        if (cur_s[2:0] != EMPTY && cur_s[3] == turn_q) begin
          fx_d    = xpos_q;
          fy_d    = ypos_q;
          state_d = HELD;
        end else begin
          err_d = 1'b1;
        end
      end else if (xpos_q == fx_q && ypos_q == fy_q) begin
        state_d = IDLE;
      end else if (cur_s[2:0] != EMPTY && cur_s[3] == turn_q) begin
        fx_d = xpos_q;
        fy_d = ypos_q;
      end else begin
        board_d[fy_q][fx_q]     = 4'd0;
        board_d[ypos_q][xpos_q] = {moved_s[3], dest_code_s};
        turn_d  = ~turn_q;
        cnt_d   = cnt_q + 10'd1;
        lx_d    = {1'b0, xpos_q} + 4'(LETTER_BASE);
        ly_d    = {1'b0, LAST} - {1'b0, ypos_q};
        state_d = IDLE;
`ifdef UNDO_EN
        uv_d   = 1'b1;
        ufx_d  = fx_q;
        ufy_d  = fy_q;
        utx_d  = xpos_q;
        uty_d  = ypos_q;
        umov_d = moved_s;
        ucap_d = cur_s;
`endif
      end
    end else if (cancel) begin
      if (state_q == HELD) state_d = IDLE;
      else                 state_d = state_q;
`ifdef UNDO_EN
    end else if (undo) begin
      if (state_q == IDLE && uv_q) begin
        board_d[ufy_q][ufx_q] = umov_q;
        board_d[uty_q][utx_q] = ucap_q;
        turn_d = ~turn_q;
        cnt_d  = cnt_q - 10'd1;
        lx_d   = 4'd0;
        ly_d   = 4'd0;
        uv_d   = 1'b0;
      end else begin
        err_d = 1'b1;
      end
`endif
    end else begin
      state_d = state_q;
    end
  end

  // State registers with synchronous reset to the opening position.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          board_q[r][c] <= init_sq(r, c);
      xpos_q  <= 3'd0;
      ypos_q  <= 3'd0;
      fx_q    <= 3'd0;
      fy_q    <= 3'd0;
      state_q <= IDLE;
      turn_q  <= 1'b0;
      cnt_q   <= 10'd0;
      lx_q    <= 4'd0;
      ly_q    <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      board_q <= board_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      state_q <= state_d;
      turn_q  <= turn_d;
      cnt_q   <= cnt_d;
      lx_q    <= lx_d;
      ly_q    <= ly_d;
      err_q   <= err_d;
    end
  end

`ifdef UNDO_EN
  // Undo buffer: last executed move and the piece it displaced.
  always_ff @(posedge clk) begin
    if (rst) begin
      uv_q   <= 1'b0;
      ufx_q  <= 3'd0;
      ufy_q  <= 3'd0;
      utx_q  <= 3'd0;
      uty_q  <= 3'd0;
      umov_q <= 4'd0;
      ucap_q <= 4'd0;
    end else begin
      uv_q   <= uv_d;
      ufx_q  <= ufx_d;
      ufy_q  <= ufy_d;
      utx_q  <= utx_d;
      uty_q  <= uty_d;
      umov_q <= umov_d;
      ucap_q <= ucap_d;
    end
  end
`endif

  logic [9:0] hrel_s, vrel_s;
  logic       on_board_s, border_s, dark_s;
  logic [2:0] hsq_s, vsq_s;
  logic [3:0] sq_s;

  // Pixel renderer: square lookup, border/cursor highlight and colour select.
  always_comb begin
    hrel_s     = hCount - 10'(X0);
    vrel_s     = vCount - 10'(Y0);
    on_board_s = ({1'b0, hCount} >= 11'(X0)) && ({1'b0, hCount} < 11'(X0 + BOARD_PX)) &&
                 ({1'b0, vCount} >= 11'(Y0)) && ({1'b0, vCount} < 11'(Y0 + BOARD_PX));
    hsq_s      = on_board_s ? 3'(hrel_s >> SQ_LOG2) : 3'd0;
    vsq_s      = on_board_s ? 3'(vrel_s >> SQ_LOG2) : 3'd0;
    px_x       = hrel_s[SQ_LOG2-1:0];
    px_y       = vrel_s[SQ_LOG2-1:0];
    sq_s       = board_q[vsq_s][hsq_s];
    sq_piece   = on_board_s ? sq_s[2:0] : EMPTY;
    border_s   = (px_x == {SQ_LOG2{1'b0}}) || (px_x == {SQ_LOG2{1'b1}}) ||
                 (px_y == {SQ_LOG2{1'b0}}) || (px_y == {SQ_LOG2{1'b1}});
    dark_s     = (hsq_s[0] == vsq_s[0]);
    if (!bright)
      rgb = 12'h000;
    else if (!on_board_s)
      rgb = 12'h0C8;
    else if (state_q == HELD && hsq_s == fx_q && vsq_s == fy_q && border_s)
      rgb = 12'hF00;
    else if (hsq_s == xpos_q && vsq_s == ypos_q && border_s)
      rgb = 12'h0F0;
    else if (sprite_on && sq_s[2:0] != EMPTY)
      rgb = sq_s[3] ? 12'h000 : 12'hFFF;
    else if (dark_s)
      rgb = 12'h753;
    else
      rgb = 12'h995;
  end

  assign held       = (state_q == HELD);
  assign err        = err_q;
  assign turn       = turn_q;
  assign move_count = cnt_q;
  assign last_x     = lx_q;
  assign last_y     = ly_q;

endmodule
